ttc_chanb_scheduler: RTL and testbench

TTC_CHANB_SCHEDULER -- requirements
Module: ttc_chanb_scheduler

---
 rtl/ttc_chanb_pkg.sv | 30 +++
 rtl/ttc_chanb_scheduler_if.sv | 15 +
 rtl/ttc_chanb_scheduler_rr_arbiter4.sv | 40 ++++
 rtl/ttc_chanb_scheduler.sv | 144 ++++++++++++++
 tb/tb_ttc_chanb_scheduler.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ttc_chanb_pkg.sv
// Shared definitions for the TTC channel-B scheduler: requester indices,
// broadcast command encodings and FSM state constants.
package ttc_chanb_pkg;

    localparam int REQ_EVT_RST = 0;
    localparam int REQ_TS_RST  = 1;
    localparam int REQ_FILL    = 2;
    localparam int REQ_STORAGE = 3;

    localparam logic [5:0] CMD_EVT_RST = 6'b000000;
    localparam logic [5:0] CMD_TS_RST  = 6'b001010;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_GAP   = 2'd2;

    // Brcst[7:2] payload for a one-hot grant.
    function automatic logic [5:0] chanb_encode(input logic [3:0] grant,
                                                input logic [1:0] fill_sel,
                                                input logic       storage_stop);
        logic [5:0] cmd;
        cmd = CMD_EVT_RST;
        if (grant[REQ_TS_RST])  cmd = CMD_TS_RST;
        if (grant[REQ_FILL])    cmd = {1'b1, fill_sel, 3'b000};
        if (grant[REQ_STORAGE]) cmd = {2'b10, storage_stop, 3'b010};
        return cmd;
    endfunction

endpackage

// File: rtl/ttc_chanb_scheduler_if.sv
// Request/acknowledge and broadcast bundle of the channel-B scheduler.
interface ttc_chanb_scheduler_if;
    logic [3:0] req;
    logic [1:0] fill_sel;
    logic       storage_stop;
    logic [3:0] ack;
    logic [5:0] chan_b_info;
    logic       chan_b_valid;
    logic       evt_count_reset;

    modport master (output req, fill_sel, storage_stop,
                    input  ack, chan_b_info, chan_b_valid, evt_count_reset);
    modport slave  (input  req, fill_sel, storage_stop,
                    output ack, chan_b_info, chan_b_valid, evt_count_reset);
endinterface

// File: rtl/ttc_chanb_scheduler_rr_arbiter4.sv
// Four-way round-robin arbiter: searches from the requester after the last
// grantee; the pointer only moves when the grant is accepted.
module rr_arbiter4 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       accept,
    output logic [3:0] grant,
    output logic       grant_valid
);
    logic [1:0] r_ptr;
    logic [1:0] w_idx;
    logic [1:0] w_grant_idx;
    logic       w_found;

    // NOTE: combinational logic uses blocking '=' with every output defaulted
    // first, so the loop reads its own updates and no latch is inferred.
    always_comb begin
        grant       = '0;
        w_grant_idx = r_ptr;
        w_found     = 1'b0;
        w_idx       = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_grant_idx  = w_idx;
                w_found      = 1'b1;
            end
        end
    end

    assign grant_valid = |req;

    // Pointer resets to 3 so requester 0 is searched first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    r_ptr <= 2'd3;
        else if (accept) r_ptr <= w_grant_idx;
    end
endmodule

// File: rtl/ttc_chanb_scheduler.sv
// TTC channel-B broadcast scheduler: latches request pulses, issues one
// broadcast at a time with a programmable gap. Stats: CHANB_SCHED_STATS_EN.
module ttc_chanb_scheduler
    import ttc_chanb_pkg::*;
#(
    parameter int GAP_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [GAP_W-1:0]       min_gap,
    ttc_chanb_scheduler_if.slave   bus,
    output logic                   busy,
    output logic [31:0]            issued_count,
    output logic [31:0]            dropped_count
);
    state_t           r_state;
    logic [3:0]       r_pending;
    logic [1:0]       r_fill_sel;
    logic             r_storage_stop;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [3:0]       r_ack;
    logic [5:0]       r_info;
    logic             r_valid;
    logic             r_evt_rst;

    logic [3:0]       w_grant;
    logic             w_grant_valid;
    logic             w_accept;
    logic [1:0]       w_fill_sel;
    logic             w_storage_stop;

    rr_arbiter4 u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (r_pending),
        .accept      (w_accept),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    assign w_accept = (r_state == ST_IDLE) && enable && w_grant_valid;

    // A payload arriving on the grant edge is the newest and must be used.
    assign w_fill_sel     = bus.req[REQ_FILL]    ? bus.fill_sel     : r_fill_sel;
    assign w_storage_stop = bus.req[REQ_STORAGE] ? bus.storage_stop : r_storage_stop;

    // NOTE: every register, including payload and gap counter, is cleared by
    // the async reset so no stale command can leak out after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending      <= '0;
            r_fill_sel     <= '0;
            r_storage_stop <= 1'b0;
        end else begin
            // r_ack is non-zero only in ISSUE; a coincident request re-sets.
            r_pending <= (r_pending & ~r_ack) | bus.req;
            if (bus.req[REQ_FILL])    r_fill_sel     <= bus.fill_sel;
            if (bus.req[REQ_STORAGE]) r_storage_stop <= bus.storage_stop;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
            r_ack     <= '0;
            r_info    <= '0;
            r_valid   <= 1'b0;
            r_evt_rst <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_info    <= '0;
            r_valid   <= 1'b0;
            r_evt_rst <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_ISSUE;
                        r_ack     <= w_grant;
                        r_info    <= chanb_encode(w_grant, w_fill_sel, w_storage_stop);
                        r_valid   <= 1'b1;
                        r_evt_rst <= w_grant[REQ_EVT_RST];
                    end
                end
                ST_ISSUE: begin
                    if (min_gap != '0) begin
                        r_state   <= ST_GAP;
                        r_gap_cnt <= min_gap;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    if (r_gap_cnt <= GAP_W'(1)) begin
                        r_state   <= ST_IDLE;
                        r_gap_cnt <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack             = r_ack;
    assign bus.chan_b_info     = r_info;
    assign bus.chan_b_valid    = r_valid;
    assign bus.evt_count_reset = r_evt_rst;
    assign busy                = (|r_pending) || (r_state != ST_IDLE);

`ifdef CHANB_SCHED_STATS_EN
    logic [31:0] r_issued;
    logic [31:0] r_dropped;
    logic [3:0]  w_drop;
    logic [2:0]  w_drop_n;
    logic [32:0] w_issued_sum;
    logic [32:0] w_dropped_sum;

    // A request is dropped only if it merges into a still-pending one.
    assign w_drop        = bus.req & r_pending & ~r_ack;
    assign w_drop_n      = {2'b0, w_drop[0]} + {2'b0, w_drop[1]}
                         + {2'b0, w_drop[2]} + {2'b0, w_drop[3]};
    assign w_issued_sum  = {1'b0, r_issued} + {32'b0, r_valid};
    assign w_dropped_sum = {1'b0, r_dropped} + {30'b0, w_drop_n};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_issued  <= '0;
            r_dropped <= '0;
        end else begin
            r_issued  <= w_issued_sum[32]  ? '1 : w_issued_sum[31:0];
            r_dropped <= w_dropped_sum[32] ? '1 : w_dropped_sum[31:0];
        end
    end

    assign issued_count  = r_issued;
    assign dropped_count = r_dropped;
`else
    assign issued_count  = '0;
    assign dropped_count = '0;
`endif

endmodule

// File: tb/tb_ttc_chanb_scheduler.sv
// Directed bench for ttc_chanb_scheduler; expectations are hand-computed
// and adjust for CHANB_SCHED_STATS_EN.
module tb_ttc_chanb_scheduler;

`ifdef CHANB_SCHED_STATS_EN
    localparam int EXP_DROPPED = 1;
    localparam int EXP_ISSUED  = 10;
`else
    localparam int EXP_DROPPED = 0;
    localparam int EXP_ISSUED  = 0;
`endif

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [7:0]  min_gap;
    logic        busy;
    logic [31:0] issued_count;
    logic [31:0] dropped_count;

    ttc_chanb_scheduler_if bus ();

    ttc_chanb_scheduler #(.GAP_W(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .min_gap       (min_gap),
        .bus           (bus),
        .busy          (busy),
        .issued_count  (issued_count),
        .dropped_count (dropped_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (bus.chan_b_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen && bus.chan_b_valid) seen = 1'b1;
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && busy; i++) tick();
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.chan_b_valid) cnt++;
        end
    endtask

    int          pulses;
    int          t_req;
    int          t_last;
    logic [3:0]  exp_ack   [4];
    logic [5:0]  exp_info  [4];

    initial begin
        reset_n          = 1'b0;
        enable           = 1'b0;
        min_gap          = 8'd0;
        bus.req          = 4'b0000;
        bus.fill_sel     = 2'b00;
        bus.storage_stop = 1'b0;
        #2;
        check("rst_valid", 32'(bus.chan_b_valid), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_info", 32'(bus.chan_b_info), 32'd0);
        check("rst_evt", 32'(bus.evt_count_reset), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_issued", issued_count, 32'd0);
        check("rst_dropped", dropped_count, 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();

        // Event-count reset, min_gap=0: strobe two cycles after the request.
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0000;
        check("evt_early_valid", 32'(bus.chan_b_valid), 32'd0);
        check("evt_busy_pending", 32'(busy), 32'd1);
        tick();
        check("evt_valid", 32'(bus.chan_b_valid), 32'd1);
        check("evt_rst", 32'(bus.evt_count_reset), 32'd1);
        check("evt_info", 32'(bus.chan_b_info), 32'h00);
        check("evt_ack", 32'(bus.ack), 32'b0001);
        tick();
        check("evt_valid_off", 32'(bus.chan_b_valid), 32'd0);
        check("evt_ack_off", 32'(bus.ack), 32'd0);
        check("evt_idle", 32'(busy), 32'd0);

        // Fill type laser: payload latched with the request, later changes ignored.
        bus.req      = 4'b0100;
        bus.fill_sel = 2'b10;
        tick();
        bus.req      = 4'b0000;
        bus.fill_sel = 2'b01;
        tick();
        check("fill_valid", 32'(bus.chan_b_valid), 32'd1);
        check("fill_info", 32'(bus.chan_b_info), 32'b110000);
        check("fill_ack", 32'(bus.ack), 32'b0100);
        check("fill_evt", 32'(bus.evt_count_reset), 32'd0);
        count_pulses(4, pulses);
        check("fill_single", 32'(pulses), 32'd0);

        // Pulse-storage stop.
        bus.req          = 4'b1000;
        bus.storage_stop = 1'b1;
        tick();
        bus.req          = 4'b0000;
        bus.storage_stop = 1'b0;
        tick();
        check("stor_valid", 32'(bus.chan_b_valid), 32'd1);
        check("stor_info", 32'(bus.chan_b_info), 32'b101010);
        check("stor_ack", 32'(bus.ack), 32'b1000);
        count_pulses(4, pulses);
        check("stor_single", 32'(pulses), 32'd0);

        // All four at once with min_gap=3: round-robin order, 5-cycle spacing.
        exp_ack[0] = 4'b0001; exp_info[0] = 6'b000000;
        exp_ack[1] = 4'b0010; exp_info[1] = 6'b001010;
        exp_ack[2] = 4'b0100; exp_info[2] = 6'b111000;
        exp_ack[3] = 4'b1000; exp_info[3] = 6'b100010;
        min_gap          = 8'd3;
        bus.req          = 4'b1111;
        bus.fill_sel     = 2'b11;
        bus.storage_stop = 1'b0;
        t_req            = cyc;
        t_last           = 0;
        tick();
        bus.req = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wait_valid($sformatf("rr_seen%0d", k), 12);
            check($sformatf("rr_ack%0d", k), 32'(bus.ack), 32'(exp_ack[k]));
            check($sformatf("rr_info%0d", k), 32'(bus.chan_b_info), 32'(exp_info[k]));
            if (k == 0) check("rr_latency", 32'(cyc - t_req), 32'd2);
            else        check($sformatf("rr_space%0d", k), 32'(cyc - t_last), 32'd5);
            t_last = cyc;
            tick();
        end
        wait_idle("rr_idle", 10);

        // min_gap changed during GAP must not shorten the running gap.
        min_gap = 8'd4;
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0000;
        wait_valid("gap_first", 4);
        check("gap_first_info", 32'(bus.chan_b_info), 32'b001010);
        t_last = cyc;
        tick();
        min_gap = 8'd1;
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0000;
        wait_valid("gap_second", 10);
        check("gap_space", 32'(cyc - t_last), 32'd6);
        min_gap = 8'd0;
        tick();
        wait_idle("gap_idle", 6);

        // Two timestamp-reset requests while disabled: one strobe, one drop.
        enable  = 1'b0;
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0000;
        count_pulses(3, pulses);
        check("drop_hold", 32'(pulses), 32'd0);
        check("drop_busy", 32'(busy), 32'd1);
        enable = 1'b1;
        wait_valid("drop_seen", 4);
        check("drop_info", 32'(bus.chan_b_info), 32'b001010);
        count_pulses(5, pulses);
        check("drop_single", 32'(pulses), 32'd0);
        check("drop_count", dropped_count, 32'(EXP_DROPPED));
        check("issued_count", issued_count, 32'(EXP_ISSUED));

        // Pending while disabled, then reset asserted in the middle of GAP.
        enable       = 1'b0;
        min_gap      = 8'd5;
        bus.req      = 4'b0100;
        bus.fill_sel = 2'b01;
        tick();
        bus.req = 4'b0000;
        count_pulses(6, pulses);
        check("dis_no_strobe", 32'(pulses), 32'd0);
        enable = 1'b1;
        wait_valid("dis_seen", 4);
        check("dis_info", 32'(bus.chan_b_info), 32'b101000);
        tick();
        tick();
        bus.req = 4'b0001;
        tick();
        bus.req = 4'b0000;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.chan_b_valid), 32'd0);
        check("mid_rst_ack", 32'(bus.ack), 32'd0);
        check("mid_rst_info", 32'(bus.chan_b_info), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_issued", issued_count, 32'd0);
        check("mid_rst_dropped", dropped_count, 32'd0);
        tick();
        reset_n = 1'b1;
        count_pulses(10, pulses);
        check("post_rst_no_strobe", 32'(pulses), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
